// File: rtl/threshold_monitor_pkg.sv
// threshold_monitor_pkg
//   Shared types and constants for the threshold monitor.
//   - state_t    : alarm FSM states
//   - HIGH_*/LOW_*: bit slice of the packed thresholds register
package threshold_monitor_pkg;

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      ARMING    = 2'd1,
      ALARM     = 2'd2,
      DISARMING = 2'd3
   } state_t;

   localparam int HIGH_MSB = 31;
   localparam int HIGH_LSB = 16;
   localparam int LOW_MSB  = 15;
   localparam int LOW_LSB  = 0;

endpackage

// File: rtl/threshold_monitor_sat_counter.sv
// threshold_monitor_sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   : clock
//     rst   : synchronous active-high reset (count -> 0)
//     clr   : clear; when asserted together with inc the result is 1
//     inc   : increment request
//     count : current value, sticks at all-ones
module threshold_monitor_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         // Clear first, then apply this cycle's increment.
         count <= inc ? W'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/threshold_monitor.sv
// threshold_monitor
//   Compares a streaming unsigned sample against the high/low thresholds of
//   the packed thresholds register, with hysteresis and a debounce count,
//   and produces a debounced alarm level, rise/fall pulses and a saturating
//   count of alarm assertions.
//   Ports:
//     clk_i          : clock
//     rst_i          : synchronous active-high reset
//     thresholds_i   : [31:16] high threshold, [15:0] low threshold
//     sample_i       : unsigned sample
//     sample_valid_i : sample qualifier; no ready/back-pressure exists, a
//                      sample is consumed in every cycle where it is 1 and
//                      cycles where it is 0 change nothing in the FSM
//     count_clr_i    : one-cycle clear of the event counter
//     alarm_o        : debounced alarm level (registered)
//     rise_o         : one-cycle pulse with the 0->1 edge of alarm_o
//     fall_o         : one-cycle pulse with the 1->0 edge of alarm_o
//     event_count_o  : saturating count of alarm assertions
//     dbg_state      : current FSM state, for observation only
module threshold_monitor
   import threshold_monitor_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      thresholds_i,
   input  logic [15:0]      sample_i,
   input  logic             sample_valid_i,
   input  logic             count_clr_i,
   output logic             alarm_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] event_count_o,
   output state_t           dbg_state
);

   localparam int DBW = $clog2(DEBOUNCE + 1);
   // Counter value at which the next qualifying sample is the final one.
   localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE - 1);

   state_t         state_q, state_d;
   logic [DBW-1:0] deb_q, deb_d;
   logic           alarm_d;
   logic           above, below;

   // Equality with either threshold never qualifies.
   assign above = sample_i > thresholds_i[HIGH_MSB:HIGH_LSB];
   assign below = sample_i < thresholds_i[LOW_MSB:LOW_LSB];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= NORMAL;
         deb_q   <= '0;
         alarm_o <= 1'b0;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         alarm_o <= alarm_d;
         rise_o  <= alarm_d & ~alarm_o;
         fall_o  <= ~alarm_d & alarm_o;
      end
   end

   // Each state only looks at the comparison that moves it forward, so a
   // misconfigured register (low > high) still gives a single defined path.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      if (sample_valid_i) begin
         unique case (state_q)
            NORMAL: begin
               if (above) begin
                  if (DEBOUNCE == 1) begin
                     state_d = ALARM;
                     deb_d   = '0;
                  end else begin
                     state_d = ARMING;
                     deb_d   = DBW'(1);
                  end
               end
            end
            ARMING: begin
               if (!above) begin
                  state_d = NORMAL;
                  deb_d   = '0;
               end else if (deb_q == DEB_LAST) begin
                  state_d = ALARM;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_q + DBW'(1);
               end
            end
            ALARM: begin
               if (below) begin
                  if (DEBOUNCE == 1) begin
                     state_d = NORMAL;
                     deb_d   = '0;
                  end else begin
                     state_d = DISARMING;
                     deb_d   = DBW'(1);
                  end
               end
            end
            DISARMING: begin
               if (!below) begin
                  state_d = ALARM;
                  deb_d   = '0;
               end else if (deb_q == DEB_LAST) begin
                  state_d = NORMAL;
                  deb_d   = '0;
               end else begin
                  deb_d = deb_q + DBW'(1);
               end
            end
            default: begin
               state_d = NORMAL;
               deb_d   = '0;
            end
         endcase
      end
   end

   // alarm_o is a registered copy of "next state is on the alarm side", so it
   // moves on the same edge the FSM enters ALARM or returns to NORMAL.
   assign alarm_d   = (state_d == ALARM) || (state_d == DISARMING);
   assign dbg_state = state_q;

   // Incrementing on the same condition that sets rise_o keeps the counter
   // edge-aligned with the pulse.
   threshold_monitor_sat_counter #(
      .W (CNT_W)
   ) u_event_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (count_clr_i),
      .inc   (alarm_d & ~alarm_o),
      .count (event_count_o)
   );

endmodule

// File: tb/tb_threshold_monitor.sv
module tb_threshold_monitor;
   import threshold_monitor_pkg::*;

   localparam logic [15:0] S_ABOVE = 16'h0D00;
   localparam logic [15:0] S_MID   = 16'h0800;
   localparam logic [15:0] S_EQL   = 16'h0400;
   localparam logic [15:0] S_EQH   = 16'h0C00;
   localparam logic [15:0] S_BELOW = 16'h03FF;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] thresholds;
   logic [15:0] sample;
   logic        valid;
   logic        clr;

   always #5 clk = ~clk;

   logic        alarm, rise, fall;
   logic [15:0] cnt16;
   state_t      st16;
   logic        alarm2, rise2, fall2;
   logic [1:0]  cnt2;
   state_t      st2;

   threshold_monitor #(.DEBOUNCE(4), .CNT_W(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .thresholds_i   (thresholds),
      .sample_i       (sample),
      .sample_valid_i (valid),
      .count_clr_i    (clr),
      .alarm_o        (alarm),
      .rise_o         (rise),
      .fall_o         (fall),
      .event_count_o  (cnt16),
      .dbg_state      (st16)
   );

   // Narrow counter copy fed the same stimulus to observe saturation.
   threshold_monitor #(.DEBOUNCE(4), .CNT_W(2)) dut_w2 (
      .clk_i          (clk),
      .rst_i          (rst),
      .thresholds_i   (thresholds),
      .sample_i       (sample),
      .sample_valid_i (valid),
      .count_clr_i    (clr),
      .alarm_o        (alarm2),
      .rise_o         (rise2),
      .fall_o         (fall2),
      .event_count_o  (cnt2),
      .dbg_state      (st2)
   );

   // ---------------- scoreboard ----------------
   logic [20:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          exp_cnt  = 0;

   // Expected record: {alarm, rise, fall, count16, count2}
   function automatic logic [20:0] pack(input logic a, input logic r,
                                        input logic f, input int cnt);
      int c2;
      c2 = (cnt > 3) ? 3 : cnt;
      return {a, r, f, 16'(cnt), 2'(c2)};
   endfunction

   task automatic check(input string name);
      logic [20:0] got, want;
      got  = {alarm, rise, fall, cnt16, cnt2};
      want = exp_q.pop_front();
      checks++;
      // The narrow instance must share alarm/pulse behaviour too.
      if (got !== want || {alarm2, rise2, fall2} !== want[20:18]) begin
         failures++;
         $display("FAIL %s: got a=%0b r=%0b f=%0b cnt=%0d cnt2=%0d (w2 a=%0b r=%0b f=%0b), expected a=%0b r=%0b f=%0b cnt=%0d cnt2=%0d",
                  name, alarm, rise, fall, cnt16, cnt2, alarm2, rise2, fall2,
                  want[20], want[19], want[18], want[17:2], want[1:0]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic v, input logic [15:0] s,
                       input logic c, input logic [20:0] e, input string name);
      rst   = r;
      valid = v;
      sample = s;
      clr   = c;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(name);
   endtask

   task automatic alarm_cycle(input int idx);
      for (int i = 0; i < 3; i++)
         step(0, 1, S_ABOVE, 0, pack(0, 0, 0, exp_cnt), $sformatf("cyc%0d_arm%0d", idx, i));
      exp_cnt++;
      step(0, 1, S_ABOVE, 0, pack(1, 1, 0, exp_cnt), $sformatf("cyc%0d_rise", idx));
      for (int i = 0; i < 3; i++)
         step(0, 1, S_BELOW, 0, pack(1, 0, 0, exp_cnt), $sformatf("cyc%0d_dis%0d", idx, i));
      step(0, 1, S_BELOW, 0, pack(0, 0, 1, exp_cnt), $sformatf("cyc%0d_fall", idx));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        valid;
      logic [15:0] sample;
      logic        clr;
      logic [20:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [15:0] s, input logic [20:0] e);
      vec_t t;
      t.rst    = 1'b0;
      t.valid  = v;
      t.sample = s;
      t.clr    = 1'b0;
      t.exp    = e;
      tbl.push_back(t);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      valid      = 1'b0;
      sample     = '0;
      clr        = 1'b0;
      thresholds = 32'h0C00_0400;
      repeat (2) @(posedge clk);
      #1;
      step(1, 0, 16'h0, 0, pack(0, 0, 0, 0), "reset");

      // aborted debounce runs (mid-band sample, sample equal to high)
      repeat (3) add(1, S_ABOVE, pack(0, 0, 0, 0));
      add(1, S_MID, pack(0, 0, 0, 0));
      repeat (3) add(1, S_ABOVE, pack(0, 0, 0, 0));
      add(1, S_EQH, pack(0, 0, 0, 0));
      // qualifying samples separated by idle cycles
      repeat (2) add(1, S_ABOVE, pack(0, 0, 0, 0));
      repeat (3) add(0, S_BELOW, pack(0, 0, 0, 0));
      add(1, S_ABOVE, pack(0, 0, 0, 0));
      repeat (3) add(0, S_BELOW, pack(0, 0, 0, 0));
      add(1, S_ABOVE, pack(1, 1, 0, 1));
      add(0, S_ABOVE, pack(1, 0, 0, 1));
      // samples equal to low hold the alarm
      repeat (10) add(1, S_EQL, pack(1, 0, 0, 1));
      // aborted disarm, then full disarm
      repeat (2) add(1, S_BELOW, pack(1, 0, 0, 1));
      add(1, S_MID, pack(1, 0, 0, 1));
      repeat (3) add(1, S_BELOW, pack(1, 0, 0, 1));
      add(1, S_BELOW, pack(0, 0, 1, 1));
      add(0, S_BELOW, pack(0, 0, 0, 1));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].rst, tbl[i].valid, tbl[i].sample, tbl[i].clr, tbl[i].exp,
              $sformatf("vec%0d", i));

      // repeated alarms: the 2-bit counter saturates at 3
      exp_cnt = 1;
      for (int k = 0; k < 4; k++) alarm_cycle(k);

      // clear on an idle cycle
      exp_cnt = 0;
      step(0, 0, S_ABOVE, 1, pack(0, 0, 0, 0), "clr_idle");

      // clear coincident with a rise: clear then count
      for (int i = 0; i < 3; i++)
         step(0, 1, S_ABOVE, 0, pack(0, 0, 0, 0), $sformatf("clr_arm%0d", i));
      step(0, 1, S_ABOVE, 1, pack(1, 1, 0, 1), "clr_with_rise");

      // reset while disarming: no fall pulse, everything cleared
      step(0, 1, S_BELOW, 0, pack(1, 0, 0, 1), "dis0");
      step(0, 1, S_BELOW, 0, pack(1, 0, 0, 1), "dis1");
      step(1, 1, S_BELOW, 0, pack(0, 0, 0, 0), "rst_in_dis");
      step(0, 0, S_BELOW, 0, pack(0, 0, 0, 0), "after_rst");
      for (int i = 0; i < 3; i++)
         step(0, 1, S_ABOVE, 0, pack(0, 0, 0, 0), $sformatf("rearm%0d", i));
      step(0, 1, S_ABOVE, 0, pack(1, 1, 0, 1), "rearm_rise");

      // swapped thresholds (low > high): mid sample is both above and below
      thresholds = 32'h0400_0C00;
      for (int i = 0; i < 3; i++)
         step(0, 1, S_MID, 0, pack(1, 0, 0, 1), $sformatf("swap_dis%0d", i));
      step(0, 1, S_MID, 0, pack(0, 0, 1, 1), "swap_fall");
      for (int i = 0; i < 3; i++)
         step(0, 1, S_MID, 0, pack(0, 0, 0, 1), $sformatf("swap_arm%0d", i));
      step(0, 1, S_MID, 0, pack(1, 1, 0, 2), "swap_rise");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
